// File: rtl/pattern_moore.sv
// Serial bit-pattern detector (Moore FSM); out is high while the last PAT_LEN bits equal PATTERN.
// Define PATTERNMOORE_OVERLAP_EN for overlapping detection; otherwise matches do not overlap.
module pattern_moore #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011
) (
  input  logic reset,
  input  logic clk,
  input  logic in,
  output logic out
);

  localparam int ST_W = $clog2(PAT_LEN + 1);

  typedef logic [ST_W-1:0] state_t;

  localparam state_t S0     = ST_W'(0);
  localparam state_t S_LAST = ST_W'(PAT_LEN);

  if ((PAT_LEN < 2) || (PAT_LEN > 16)) begin : g_bad_len
    $error("pattern_moore: PAT_LEN must be in 2..16");
  end

  // Longest proper prefix of PATTERN that is a suffix of (prefix_k, b).
  function automatic int calc_next(input int k, input logic b);
    int   res;
    int   m;
    logic ok;
    logic sbit;
    res = 0;
    for (int j = 1; j <= PAT_LEN; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++) begin
          m    = k + 1 - j + i;
          sbit = (m == k) ? b : PATTERN[PAT_LEN-1-m];
          if (sbit != PATTERN[PAT_LEN-1-i]) begin
            ok = 1'b0;
          end else begin
            ok = ok;
          end
        end
        if (ok) begin
          res = j;
        end else begin
          res = res;
        end
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [PAT_LEN*ST_W-1:0] build_table(input logic b);
    logic [PAT_LEN*ST_W-1:0] t;
    t = '0;
    for (int k = 0; k < PAT_LEN; k++) begin
      t[k*ST_W +: ST_W] = ST_W'(calc_next(k, b));
    end
    return t;
  endfunction

  localparam logic [PAT_LEN*ST_W-1:0] NXT0 = build_table(1'b0);
  localparam logic [PAT_LEN*ST_W-1:0] NXT1 = build_table(1'b1);
  localparam state_t LAST0 = ST_W'(calc_next(PAT_LEN, 1'b0));
  localparam state_t LAST1 = ST_W'(calc_next(PAT_LEN, 1'b1));

  state_t state_q;
  state_t state_d;
  logic   out_q;

  // Next-state selection from the precomputed transition tables.
  always_comb begin
    state_d = S0;
    if (state_q < S_LAST) begin
      state_d = in ? NXT1[int'(state_q)*ST_W +: ST_W] : NXT0[int'(state_q)*ST_W +: ST_W];
    end else if (state_q == S_LAST) begin
`ifdef PATTERNMOORE_OVERLAP_EN
      state_d = in ? LAST1 : LAST0;
`else
      state_d = in ? NXT1[0 +: ST_W] : NXT0[0 +: ST_W];
`endif
    end else begin
      state_d = S0;
    end
  end

  // State and detect-flag registers; out_q mirrors (state_q == S_LAST).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= (state_d == S_LAST);
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_pattern_moore.sv
// Directed self-checking bench for pattern_moore with the default 1011 pattern.
module tb_pattern_moore;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic in    = 1'b0;
  logic out;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pattern_moore dut (
    .reset (reset),
    .clk   (clk),
    .in    (in),
    .out   (out)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: out=%b expected %b", tag, obs, exp);
  endtask

  // One clock edge with reset high and in undriven, then release reset.
  task automatic apply_reset(input string tag);
    reset = 1'b1;
    in    = 1'bx;
    @(posedge clk);
    #1;
    reset = 1'b0;
    in    = 1'b0;
    check(tag, out, 1'b0);
  endtask

  // Drive n bits (MSB first), checking out after each edge against exps.
  task automatic run_seq(input string tag, input logic [15:0] bits,
                         input logic [15:0] exps, input int n);
    for (int i = 0; i < n; i++) begin
      in = bits[n-1-i];
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", tag, i), out, exps[n-1-i]);
    end
  endtask

  logic [15:0] overlap_exp;

  initial begin
`ifdef PATTERNMOORE_OVERLAP_EN
    overlap_exp = 16'b0000_0000_0000_1001 << 0;
    overlap_exp = 16'b0001001;
`else
    overlap_exp = 16'b0001000;
`endif
    #2;
    apply_reset("reset_x");
    n_total++;
    assert (dut.state_q === 3'd0) n_pass++;
    else $error("FAIL reset_state: state=%0d expected 0", dut.state_q);
    run_seq("idle_zeros", 16'b000, 16'b000, 3);

    run_seq("basic", 16'b10110, 16'b00010, 5);

    apply_reset("reset_ov");
    run_seq("overlap", 16'b1011011, overlap_exp, 7);

    apply_reset("reset_nm");
    run_seq("near_miss", 16'b100111010, 16'b000000000, 9);

    apply_reset("reset_rec");
    run_seq("recovery", 16'b11011, 16'b00001, 5);

    apply_reset("reset_mid0");
    run_seq("mid_prefix", 16'b101, 16'b000, 3);
    apply_reset("reset_mid");
    run_seq("mid_after", 16'b1, 16'b0, 1);
    run_seq("mid_finish", 16'b011, 16'b001, 3);

    apply_reset("reset_while_out");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
